// File: rtl/hwpe_ctrl_package.sv
// Purpose: shared register map, acquire-busy code and FSM encoding for the HWPE offload master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hwpe_ctrl_package;

    // Word indices of the HWPE control slave registers
    localparam logic [31:0] REG_TRIGGER  = 32'd0;
    localparam logic [31:0] REG_ACQUIRE  = 32'd1;

    // Value read back from the acquire register while every context is taken
    localparam logic [31:0] ACQUIRE_BUSY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        BACKOFF,
        WRITE,
        TRIG,
        WAIT_EVT,
        DONE
    } offload_state_e;

    // Byte address of a register word; the low bits are forced to zero so the
    // bus never sees an unaligned address.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] idx);
        return (base + (idx << 2)) & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Purpose: peripheral-interconnect request/response bundle between an initiator and an HWPE control slave.
// Latency: n/a (wires only).
// Backpressure: initiator holds req until gnt; response returned later on r_valid tagged with r_id.
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 16
) ();
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_ctrl_offload_master.sv
// Purpose: offloads one job to an HWPE: acquire a context, write job registers, trigger, wait for completion event.
// Latency: with gnt in the request cycle and r_valid one cycle later, job accept to trigger grant spans 2*(N_JOB_REGS+2) cycles.
// Backpressure: one transaction in flight; req held stable until gnt, next req only after the matching r_valid.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg                      peripheral-interconnect initiator towards the HWPE control slave
//   job_valid_i/job_ready_o  job handshake, job_data_i holds N_JOB_REGS 32-bit words
//   evt_i                    completion event from the HWPE
//   busy_o, done_o           offload in flight / one-cycle completion pulse
//   context_o                context id returned by the acquire read
//   timeout_o                one-cycle watchdog pulse
// Build option: HWPE_OFFLOAD_TIMEOUT_EN compiles in the event-wait watchdog.
module hwpe_ctrl_offload_master
    import hwpe_ctrl_package::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned N_JOB_REGS     = 4,
    parameter int unsigned JOB_REG_IDX    = 8,
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned CORE_ID        = 0,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    hwpe_ctrl_intf_periph.master        cfg,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [N_JOB_REGS-1:0][31:0] job_data_i,
    input  logic                        evt_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [7:0]                  context_o,
    output logic                        timeout_o
);

    localparam int unsigned IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
`else
    localparam int unsigned CNT_MAX = BACKOFF_CYCLES;
`endif
    localparam int unsigned         CNT_W        = $clog2(CNT_MAX + 2);
    localparam logic [ID_WIDTH-1:0] ID_ONEHOT    = ID_WIDTH'(1) << CORE_ID;
    localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(N_JOB_REGS - 1);
    localparam logic [CNT_W-1:0]    BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);

    offload_state_e              r_state;
    offload_state_e              w_state_nxt;
    logic [N_JOB_REGS-1:0][31:0] r_job;
    logic [IDX_W-1:0]            r_idx;
    logic [CNT_W-1:0]            r_cnt;     // backoff and watchdog share this counter
    logic                        r_pend;    // granted, response not yet seen
    logic [7:0]                  r_ctx;

    logic                        w_req;
    logic                        w_wen;
    logic [31:0]                 w_add;
    logic [31:0]                 w_dat;
    logic [3:0]                  w_be;
    logic                        w_rsp;
    logic                        w_cnt_run;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic                        r_timeout;
    logic                        w_tmo;
`else
    // The watchdog limit is only consumed by the watchdog build.
    logic                        w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Only our own response to our own outstanding request is accepted.
    assign w_rsp = r_pend && cfg.r_valid && (cfg.r_id == ID_ONEHOT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_wen       = 1'b0;
        w_add       = 32'h0;
        w_dat       = 32'h0;
        w_be        = 4'h0;
        w_cnt_run   = 1'b0;
        job_ready_o = 1'b0;
        done_o      = 1'b0;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
        w_tmo       = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) w_state_nxt = ACQ;
            end
            ACQ: begin
                w_req = !r_pend;
                w_wen = 1'b1;
                w_be  = 4'hF;
                w_add = reg_addr(BASE_ADDR, REG_ACQUIRE);
                if (w_rsp) w_state_nxt = (cfg.r_data == ACQUIRE_BUSY) ? BACKOFF : WRITE;
            end
            BACKOFF: begin
                if (r_cnt == BACKOFF_LAST) w_state_nxt = ACQ;
                else                       w_cnt_run   = 1'b1;
            end
            WRITE: begin
                w_req = !r_pend;
                w_be  = 4'hF;
                w_add = reg_addr(BASE_ADDR, 32'(JOB_REG_IDX) + 32'(r_idx));
                w_dat = r_job[r_idx];
                if (w_rsp && (r_idx == IDX_LAST)) w_state_nxt = TRIG;
            end
            TRIG: begin
                w_req = !r_pend;
                w_be  = 4'hF;
                w_add = reg_addr(BASE_ADDR, REG_TRIGGER);
                if (w_rsp) w_state_nxt = WAIT_EVT;
            end
            WAIT_EVT: begin
                // evt_i is checked first so it wins against a simultaneous timeout
                if (evt_i) begin
                    w_state_nxt = DONE;
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmo       = 1'b1;
                end else begin
                    w_cnt_run   = 1'b1;
`endif
                end
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_job  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_ctx  <= 8'h0;
        end else begin
            if ((r_state == IDLE) && job_valid_i) r_job <= job_data_i;

            if (w_req && cfg.gnt) r_pend <= 1'b1;
            else if (w_rsp)       r_pend <= 1'b0;

            if ((r_state == ACQ) && w_rsp && (cfg.r_data != ACQUIRE_BUSY)) r_ctx <= cfg.r_data[7:0];

            if ((r_state == WRITE) && w_rsp) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

            if (w_cnt_run) r_cnt <= r_cnt + CNT_W'(1);
            else           r_cnt <= '0;
        end
    end

`ifdef HWPE_OFFLOAD_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_timeout <= 1'b0;
        else         r_timeout <= w_tmo;
    end
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign cfg.req   = w_req;
    assign cfg.wen   = w_wen;
    assign cfg.add   = w_add;
    assign cfg.data  = w_dat;
    assign cfg.be    = w_be;
    assign cfg.id    = ID_ONEHOT;
    assign busy_o    = (r_state != IDLE);
    assign context_o = r_ctx;

endmodule

// File: tb/tb_hwpe_ctrl_offload_master.sv
module tb_hwpe_ctrl_offload_master;

    localparam int unsigned N     = 4;
    localparam int unsigned BO    = 8;
    localparam logic [15:0] MY_ID = 16'h0001;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
        logic [15:0] id;
        int          cyc;
    } txn_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               job_valid;
    logic               job_ready;
    logic [N-1:0][31:0] job_dat;
    logic               evt;
    logic               busy;
    logic               done;
    logic [7:0]         ctx;
    logic               tmo;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // slave model state and knobs
    txn_t        log_q[$];
    logic [31:0] acq_q[$];
    logic [31:0] acq_dflt   = 32'h0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    int          wrong_left = 0;
    bit          rsp_due    = 1'b0;
    logic [31:0] rsp_dat    = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(16)) cfg_if ();

    hwpe_ctrl_offload_master #(
        .BASE_ADDR      (32'h0),
        .N_JOB_REGS     (N),
        .JOB_REG_IDX    (8),
        .ID_WIDTH       (16),
        .CORE_ID        (0),
        .BACKOFF_CYCLES (BO),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg         (cfg_if),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_data_i  (job_dat),
        .evt_i       (evt),
        .busy_o      (busy),
        .done_o      (done),
        .context_o   (ctx),
        .timeout_o   (tmo)
    );

    // Slave: gnt in the request cycle (unless stalled), response one cycle later.
    initial begin
        cfg_if.gnt     = 1'b0;
        cfg_if.r_valid = 1'b0;
        cfg_if.r_data  = 32'h0;
        cfg_if.r_id    = 16'h0;
        forever begin
            @(negedge clk);
            cfg_if.gnt     = 1'b0;
            cfg_if.r_valid = 1'b0;
            if (!rst_n) begin
                rsp_due = 1'b0;
            end else if (rsp_due) begin
                cfg_if.r_valid = 1'b1;
                if (wrong_left > 0) begin
                    cfg_if.r_id   = 16'h0002;
                    cfg_if.r_data = 32'hFFFF_FFFF;
                    wrong_left--;
                end else begin
                    cfg_if.r_id   = MY_ID;
                    cfg_if.r_data = rsp_dat;
                    rsp_due       = 1'b0;
                end
            end else if (cfg_if.req) begin
                if (!cfg_if.wen && (cfg_if.add == stall_addr) && (stall_left > 0)) begin
                    stall_left--;
                end else begin
                    cfg_if.gnt = 1'b1;
                    log_q.push_back('{cfg_if.wen, cfg_if.add, cfg_if.data, cfg_if.id, cyc});
                    rsp_due = 1'b1;
                    if (cfg_if.wen) rsp_dat = (acq_q.size() > 0) ? acq_q.pop_front() : acq_dflt;
                    else            rsp_dat = 32'h0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic run_job(input logic [N-1:0][31:0] d, output int acc);
        int k;
        k = 0;
        @(negedge clk);
        while (!job_ready && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_wait: job_ready=%b after %0d cycles, required 1", job_ready, k);
        end
        job_valid = 1'b1;
        job_dat   = d;
        acc       = cyc;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        checks++;
        if (log_q.size() < n) begin
            errors++;
            $display("FAIL wait_log: %0d transactions seen, %0d required", log_q.size(), n);
        end
    endtask

    task automatic fire_evt;
        repeat (2) @(negedge clk);
        evt = 1'b1;
        @(negedge clk);
        evt = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; job_valid = 1'b0; evt = 1'b0; job_dat = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cfg_if.req !== 1'b0 || done !== 1'b0 || tmo !== 1'b0 || busy !== 1'b0 || ctx !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b done=%b tmo=%b busy=%b ctx=%h, required all 0", cfg_if.req, done, tmo, busy, ctx);
        end
        checks++;
        if (job_ready !== 1'b1 || cfg_if.add !== 32'h0 || cfg_if.data !== 32'h0 || cfg_if.be !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus: job_ready=%b add=%h data=%h be=%h, required 1/0/0/0", job_ready, cfg_if.add, cfg_if.data, cfg_if.be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cfg_if.req !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b req=%b job_ready=%b, required 0/0/1", busy, cfg_if.req, job_ready);
        end
    endtask

    task automatic test_basic;
        logic [N-1:0][31:0] d;
        int acc;
        d = {32'hD000_000D, 32'hC000_000C, 32'hB000_000B, 32'hA000_000A};
        log_q.delete(); acq_dflt = 32'h0000_0005;
        run_job(d, acc);
        evt = 1'b1;                       // lands in ACQ and must be forgotten
        @(negedge clk);
        evt = 1'b0;
        wait_log(6, 200);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_evt_ignored: done=%b busy=%b, required 0/1", done, busy);
        end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            logic [31:0] ea, ed;
            logic        ew;
            ew = (i == 0); ea = 32'h0; ed = 32'h0;
            if (i == 0) ea = 32'd4;
            else if (i <= N) begin ea = 32'(4 * (8 + i - 1)); ed = d[2'(i - 1)]; end
            checks++;
            if (log_q[i].wen !== ew || log_q[i].add !== ea || log_q[i].id !== MY_ID || (!ew && log_q[i].data !== ed)) begin
                errors++;
                $display("FAIL basic_txn%0d: wen=%b add=%h data=%h id=%h, required wen=%b add=%h data=%h id=%h",
                         i, log_q[i].wen, log_q[i].add, log_q[i].data, log_q[i].id, ew, ea, ed, MY_ID);
            end
        end
        // acceptance cycle and trigger-grant cycle both counted
        checks++;
        if (log_q.size() >= 6 && (log_q[5].cyc - acc + 1) != 2 * (N + 2)) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, required %0d", log_q[5].cyc - acc + 1, 2 * (N + 2));
        end
        fire_evt();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b busy=%b, required 1/1", done, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1 || ctx !== 8'h05 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b ready=%b ctx=%h tmo=%b, required 0/0/1/05/0", done, busy, job_ready, ctx, tmo);
        end
    endtask

    task automatic test_backoff;
        logic [N-1:0][31:0] d;
        int acc;
        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        log_q.delete();
        acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'h0000_0001);
        run_job(d, acc);
        wait_log(8, 300);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].wen !== 1'b1 || log_q[i].add !== 32'd4) begin
                errors++;
                $display("FAIL backoff_acq%0d: wen=%b add=%h, required 1/00000004", i, log_q[i].wen, log_q[i].add);
            end
        end
        // request, response, then BO idle cycles before the next request
        for (int i = 1; i < 3 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i].cyc - log_q[i-1].cyc != BO + 2) begin
                errors++;
                $display("FAIL backoff_gap%0d: %0d cycles, required %0d", i, log_q[i].cyc - log_q[i-1].cyc, BO + 2);
            end
        end
        checks++;
        if (log_q.size() >= 4 && (log_q[3].wen !== 1'b0 || log_q[3].add !== 32'd32 || log_q[3].data !== 32'h1111_1111)) begin
            errors++;
            $display("FAIL backoff_first_write: wen=%b add=%h data=%h, required 0/00000020/11111111", log_q[3].wen, log_q[3].add, log_q[3].data);
        end
        fire_evt();
        @(negedge clk);
        #1;
        checks++;
        if (ctx !== 8'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backoff_context: ctx=%h busy=%b, required 01/0", ctx, busy);
        end
    endtask

    task automatic test_gnt_stall;
        logic [N-1:0][31:0] d;
        int acc;
        int k;
        int stable;
        d = {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A};
        log_q.delete(); acq_dflt = 32'h0000_0002;
        stall_addr = 32'd36; stall_left = 5;
        run_job(d, acc);
        k = 0;
        #1;
        while (!(cfg_if.req && !cfg_if.wen && cfg_if.add == 32'd36) && k < 50) begin @(negedge clk); #1; k++; end
        stable = 0;
        for (int i = 0; i < 6; i++) begin
            if (cfg_if.req === 1'b1 && cfg_if.add === 32'd36 && cfg_if.data === 32'h0B0B_0B0B && cfg_if.be === 4'hF) stable++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stable != 6) begin
            errors++;
            $display("FAIL stall_stable: %0d stable request cycles, required 6", stable);
        end
        checks++;
        if (cfg_if.req !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_outstanding: req=%b after grant, required 0", cfg_if.req);
        end
        wait_log(6, 200);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            logic [31:0] ea, ed;
            logic        ew;
            ew = (i == 0); ea = 32'h0; ed = 32'h0;
            if (i == 0) ea = 32'd4;
            else if (i <= N) begin ea = 32'(4 * (8 + i - 1)); ed = d[2'(i - 1)]; end
            checks++;
            if (log_q[i].wen !== ew || log_q[i].add !== ea || (!ew && log_q[i].data !== ed)) begin
                errors++;
                $display("FAIL stall_txn%0d: wen=%b add=%h data=%h, required wen=%b add=%h data=%h",
                         i, log_q[i].wen, log_q[i].add, log_q[i].data, ew, ea, ed);
            end
        end
        checks++;
        if (log_q.size() >= 3 && (log_q[2].cyc - log_q[1].cyc) != 7) begin
            errors++;
            $display("FAIL stall_gap: %0d cycles between write grants, required 7", log_q[2].cyc - log_q[1].cyc);
        end
        stall_addr = 32'hFFFF_FFFF;
        fire_evt();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done=%b, required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_wrong_id;
        logic [N-1:0][31:0] d;
        int acc;
        d = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        log_q.delete(); acq_dflt = 32'h0000_0007;
        wrong_left = 1;                   // foreign response carries the busy code
        run_job(d, acc);
        wait_log(2, 100);
        checks++;
        if (log_q.size() >= 2 && (log_q[1].cyc - log_q[0].cyc != 3 || log_q[1].wen !== 1'b0 || log_q[1].add !== 32'd32)) begin
            errors++;
            $display("FAIL wrong_id_ignored: gap=%0d wen=%b add=%h, required 3/0/00000020",
                     log_q[1].cyc - log_q[0].cyc, log_q[1].wen, log_q[1].add);
        end
        wait_log(6, 200);
        fire_evt();
        @(negedge clk);
        #1;
        checks++;
        if (ctx !== 8'h07 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrong_id_context: ctx=%h busy=%b, required 07/0", ctx, busy);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [N-1:0][31:0] d;
        int acc;
        d = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
        log_q.delete(); acq_dflt = 32'h0000_0009;
        run_job(d, acc);
        wait_log(2, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cfg_if.req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ctx !== 8'h0 || tmo !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: req=%b busy=%b done=%b ctx=%h tmo=%b ready=%b, required 0/0/0/00/0/1",
                     cfg_if.req, busy, done, ctx, tmo, job_ready);
        end
        checks++;
        if (cfg_if.add !== 32'h0 || cfg_if.data !== 32'h0 || cfg_if.be !== 4'h0) begin
            errors++;
            $display("FAIL midreset_bus: add=%h data=%h be=%h, required 0/0/0", cfg_if.add, cfg_if.data, cfg_if.be);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (cfg_if.req !== 1'b0 || log_q.size() != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: req=%b txns=%0d busy=%b, required 0/2/0", cfg_if.req, log_q.size(), busy);
        end
        d = {32'hBEEF_0004, 32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001};
        log_q.delete();
        run_job(d, acc);
        wait_log(6, 200);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            logic [31:0] ea, ed;
            logic        ew;
            ew = (i == 0); ea = 32'h0; ed = 32'h0;
            if (i == 0) ea = 32'd4;
            else if (i <= N) begin ea = 32'(4 * (8 + i - 1)); ed = d[2'(i - 1)]; end
            checks++;
            if (log_q[i].wen !== ew || log_q[i].add !== ea || (!ew && log_q[i].data !== ed)) begin
                errors++;
                $display("FAIL midreset_txn%0d: wen=%b add=%h data=%h, required wen=%b add=%h data=%h",
                         i, log_q[i].wen, log_q[i].add, log_q[i].data, ew, ea, ed);
            end
        end
        fire_evt();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_done: done=%b, required 1", done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctx !== 8'h09 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_context: ctx=%h busy=%b, required 09/0", ctx, busy);
        end
    endtask

`ifdef HWPE_OFFLOAD_TIMEOUT_EN
    task automatic test_timeout;
        logic [N-1:0][31:0] d;
        int acc;
        int t_trig;
        int t_tmo;
        bit saw_done;
        d = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        log_q.delete(); acq_dflt = 32'h0000_0003;
        run_job(d, acc);
        wait_log(6, 200);
        t_trig   = (log_q.size() >= 6) ? log_q[5].cyc : -100;
        t_tmo    = -1;
        saw_done = 1'b0;
        for (int k = 0; k < 40 && t_tmo < 0; k++) begin
            @(negedge clk);
            #1;
            if (done) saw_done = 1'b1;
            if (tmo)  t_tmo    = cyc;
        end
        // WAIT_EVT is entered two cycles after the trigger grant
        checks++;
        if (t_tmo != t_trig + 2 + 16) begin
            errors++;
            $display("FAIL timeout_cycle: pulse at %0d, required %0d", t_tmo, t_trig + 18);
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL timeout_no_done: done seen=%b, required 0", saw_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (tmo !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_end: tmo=%b busy=%b, required 0/0", tmo, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backoff();
        test_gnt_stall();
        test_wrong_id();
        test_reset_mid_write();
`ifdef HWPE_OFFLOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
